// File: rtl/out_writeback.sv
// out_writeback: buffers result rows from the activation stage and writes
// them to BRAM at base + k*stride, with per-lane write masking. Rows are
// held in a small FIFO while the reader owns the BRAM port.
//
// Ports
//   clk, reset            sole clock, asynchronous active-high reset
//   start                 one-cycle pulse: latch config, (re)start a job
//   address_mat_c         base BRAM address (sampled on start)
//   address_stride_c      per-row address increment (sampled on start)
//   validity_mask         per-lane write enable (sampled on start)
//   in_data_available     in_data carries a row this cycle
//   in_data               one result row
//   port_busy             BRAM port owned by the reader; hold writes
//   bram_addr/wdata/we    registered BRAM write interface
//   wr_valid              a write is driven this cycle
//   busy                  job in progress
//   done                  one-cycle completion pulse
//   overflow              sticky: a row was dropped on a full FIFO
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | no job; incoming rows ignored
// ACTIVE | accepting rows and draining the FIFO to BRAM
// DONE   | all rows written; done asserted for this single cycle

`ifndef DWIDTH
`define DWIDTH 8
`endif
`ifndef MAT_MUL_SIZE
`define MAT_MUL_SIZE 4
`endif
`ifndef AWIDTH
`define AWIDTH 10
`endif
`ifndef ADDR_STRIDE_WIDTH
`define ADDR_STRIDE_WIDTH 8
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH `MAT_MUL_SIZE
`endif

module out_writeback #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_ROWS   = `MAT_MUL_SIZE
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [`AWIDTH-1:0]                  address_mat_c,
    input  logic [`ADDR_STRIDE_WIDTH-1:0]       address_stride_c,
    input  logic [`MASK_WIDTH-1:0]              validity_mask,
    input  logic                                in_data_available,
    input  logic [`MAT_MUL_SIZE*`DWIDTH-1:0]    in_data,
    input  logic                                port_busy,
    output logic [`AWIDTH-1:0]                  bram_addr,
    output logic [`MAT_MUL_SIZE*`DWIDTH-1:0]    bram_wdata,
    output logic [`MASK_WIDTH-1:0]              bram_we,
    output logic                                wr_valid,
    output logic                                busy,
    output logic                                done,
    output logic                                overflow
);

    localparam int ROW_W  = `MAT_MUL_SIZE * `DWIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ROWS_W = $clog2(NUM_ROWS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [`ADDR_STRIDE_WIDTH-1:0] stride_q, stride_d;
    logic [`MASK_WIDTH-1:0]        mask_q, mask_d;
    logic [`AWIDTH-1:0]            addr_next_q, addr_next_d;
    logic [ROWS_W-1:0]             accept_left_q, accept_left_d;
    logic [ROWS_W-1:0]             writes_left_q, writes_left_d;
    logic                          overflow_q, overflow_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]              count_q, count_d;

    logic [`AWIDTH-1:0]            bram_addr_q, bram_addr_d;
    logic [ROW_W-1:0]              bram_wdata_q, bram_wdata_d;
    logic [`MASK_WIDTH-1:0]        bram_we_q, bram_we_d;
    logic                          wr_valid_q, wr_valid_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;

    logic [ROW_W-1:0]              fifo_mem [FIFO_DEPTH];

    logic             active;
    logic             want_push;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic [ROW_W-1:0] head_row;
    logic [ROW_W-1:0] masked_row;

    // A start in the same cycle overrides everything: nothing is pushed or
    // popped while the job is being re-initialised.
    always_comb begin
        active     = (state_q == ST_ACTIVE) && !start;
        want_push  = active && in_data_available && (accept_left_q != '0);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        // Popping on an empty FIFO is allowed when a row arrives this cycle:
        // the row bypasses storage so it reaches the outputs one cycle later.
        pop        = active && !port_busy && (!fifo_empty || want_push);
        push_ok    = want_push && (!fifo_full || pop);
        drop       = want_push && fifo_full && !pop;
        head_row   = fifo_empty ? in_data : fifo_mem[rd_ptr_q];
    end

    always_comb begin
        masked_row = '0;
        for (int i = 0; i < `MAT_MUL_SIZE; i++) begin
            masked_row[i*`DWIDTH +: `DWIDTH] =
                head_row[i*`DWIDTH +: `DWIDTH] & {`DWIDTH{mask_q[i]}};
        end
    end

    always_comb begin
        state_d       = state_q;
        stride_d      = stride_q;
        mask_d        = mask_q;
        addr_next_d   = addr_next_q;
        accept_left_d = accept_left_q;
        writes_left_d = writes_left_q;
        overflow_d    = overflow_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (start) begin
            state_d       = ST_ACTIVE;
            stride_d      = address_stride_c;
            mask_d        = validity_mask;
            addr_next_d   = address_mat_c;
            accept_left_d = ROWS_W'(NUM_ROWS);
            writes_left_d = ROWS_W'(NUM_ROWS);
            overflow_d    = 1'b0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (want_push) accept_left_d = accept_left_q - ROWS_W'(1);
                    if (push_ok)   wr_ptr_d      = wr_ptr_q + PTR_W'(1);
                    if (pop) begin
                        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                        addr_next_d = addr_next_q + `AWIDTH'(stride_q);
                    end
                    if (drop) overflow_d = 1'b1;
                    // A dropped row will never be written, so it retires a
                    // pending write just like a pop does.
                    if (pop || drop) writes_left_d = writes_left_q - ROWS_W'(1);
                    case ({push_ok, pop})
                        2'b10:   count_d = count_q + CNT_W'(1);
                        2'b01:   count_d = count_q - CNT_W'(1);
                        default: count_d = count_q;
                    endcase
                    // Last pop has moved into the output register by now, so
                    // done lands one cycle after the final write.
                    if (writes_left_q == '0) state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_valid_d   = pop;
        bram_addr_d  = pop ? addr_next_q : '0;
        bram_we_d    = pop ? mask_q : '0;
        bram_wdata_d = pop ? masked_row : '0;
        busy_d       = (state_d == ST_ACTIVE);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            stride_q      <= '0;
            mask_q        <= '0;
            addr_next_q   <= '0;
            accept_left_q <= '0;
            writes_left_q <= '0;
            overflow_q    <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            bram_addr_q   <= '0;
            bram_wdata_q  <= '0;
            bram_we_q     <= '0;
            wr_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            stride_q      <= stride_d;
            mask_q        <= mask_d;
            addr_next_q   <= addr_next_d;
            accept_left_q <= accept_left_d;
            writes_left_q <= writes_left_d;
            overflow_q    <= overflow_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            bram_addr_q   <= bram_addr_d;
            bram_wdata_q  <= bram_wdata_d;
            bram_we_q     <= bram_we_d;
            wr_valid_q    <= wr_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Storage needs no reset: entries are only read behind count_q.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= in_data;
    end

    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign bram_we    = bram_we_q;
    assign wr_valid   = wr_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_out_writeback.sv
// Bench for out_writeback: a depth-4 instance for the main jobs and a
// depth-2 instance for the overflow job, each with its own scoreboard.

module tb_out_writeback;

    localparam int DW = `DWIDTH;
    localparam int N  = `MAT_MUL_SIZE;
    localparam int AW = `AWIDTH;
    localparam int SW = `ADDR_STRIDE_WIDTH;
    localparam int MW = `MASK_WIDTH;
    localparam int RW = N * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, start2;
    logic [AW-1:0] address_mat_c;
    logic [SW-1:0] address_stride_c;
    logic [MW-1:0] validity_mask;
    logic          in_data_available;
    logic [RW-1:0] in_data;
    logic          port_busy;

    logic [AW-1:0] bram_addr,  bram_addr2;
    logic [RW-1:0] bram_wdata, bram_wdata2;
    logic [MW-1:0] bram_we,    bram_we2;
    logic          wr_valid, wr_valid2, busy, busy2, done, done2, overflow, overflow2;

    out_writeback #(.FIFO_DEPTH(4)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .address_mat_c(address_mat_c), .address_stride_c(address_stride_c),
        .validity_mask(validity_mask), .in_data_available(in_data_available),
        .in_data(in_data), .port_busy(port_busy),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we),
        .wr_valid(wr_valid), .busy(busy), .done(done), .overflow(overflow)
    );

    out_writeback #(.FIFO_DEPTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .address_mat_c(address_mat_c), .address_stride_c(address_stride_c),
        .validity_mask(validity_mask), .in_data_available(in_data_available),
        .in_data(in_data), .port_busy(port_busy),
        .bram_addr(bram_addr2), .bram_wdata(bram_wdata2), .bram_we(bram_we2),
        .wr_valid(wr_valid2), .busy(busy2), .done(done2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [MW-1:0] we;
        logic [RW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp2_q[$];
    int  wr_cyc_q[$];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int wr_cnt = 0, wr2_cnt = 0;
    int done_cnt = 0, done2_cnt = 0, done_cyc = 0;

    logic [AW-1:0] cur_base;
    logic [SW-1:0] cur_stride;
    logic [MW-1:0] cur_mask;
    int            k_idx;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [RW-1:0] mask_row(input logic [RW-1:0] row, input logic [MW-1:0] m);
        logic [RW-1:0] r;
        r = row;
        for (int i = 0; i < N; i++)
            if (!m[i]) r[i*DW +: DW] = '0;
        return r;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int k);
        logic [31:0] a;
        a = 32'(cur_base) + 32'(k) * 32'(cur_stride);
        return a[AW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [SW-1:0] stride,
                             input logic [MW-1:0] mask, input int sel);
        address_mat_c    = base;
        address_stride_c = stride;
        validity_mask    = mask;
        cur_base         = base;
        cur_stride       = stride;
        cur_mask         = mask;
        k_idx            = 0;
        if (sel == 2) start2 = 1'b1;
        else          start  = 1'b1;
        tick();
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // tgt: 0 = no write expected, 1 = expected from u_dut, 2 = from u_dut2
    task automatic send_row(input logic [RW-1:0] row, input int tgt);
        wr_t e;
        in_data           = row;
        in_data_available = 1'b1;
        if (tgt != 0) begin
            e.addr = exp_addr(k_idx);
            e.we   = cur_mask;
            e.data = mask_row(row, cur_mask);
            if (tgt == 1) exp_q.push_back(e);
            else          exp2_q.push_back(e);
            k_idx++;
        end
        tick();
        in_data_available = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int target, input int budget);
        int n;
        n = 0;
        while (((sel == 1) ? done_cnt : done2_cnt) < target && n < budget) begin
            tick();
            n++;
        end
        check_eq((sel == 1) ? "done_seen" : "done2_seen",
                 64'(((sel == 1) ? done_cnt : done2_cnt) >= target), 64'd1);
    endtask

    task automatic check_consecutive(input string tag, input int first_cyc);
        check_eq({tag, "_nwr"}, 64'(wr_cyc_q.size()), 64'd4);
        if (wr_cyc_q.size() == 4) begin
            check_eq({tag, "_first"}, 64'(wr_cyc_q[0]), 64'(first_cyc));
            for (int i = 1; i < 4; i++)
                check_eq({tag, "_gap"}, 64'(wr_cyc_q[i] - wr_cyc_q[i-1]), 64'd1);
        end
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (!reset) begin
            if (wr_valid) begin
                wr_cnt++;
                wr_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) check_eq("unexpected_wr", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check_eq("addr",  64'(bram_addr),  64'(e.addr));
                    check_eq("we",    64'(bram_we),    64'(e.we));
                    check_eq("wdata", 64'(bram_wdata), 64'(e.data));
                end
            end else begin
                check_eq("idle_we_wdata", 64'({bram_we, bram_wdata}), 64'd0);
            end
            if (wr_valid2) begin
                wr2_cnt++;
                if (exp2_q.size() == 0) check_eq("unexpected_wr2", 64'd1, 64'd0);
                else begin
                    e = exp2_q.pop_front();
                    check_eq("addr2",  64'(bram_addr2),  64'(e.addr));
                    check_eq("we2",    64'(bram_we2),    64'(e.we));
                    check_eq("wdata2", 64'(bram_wdata2), 64'(e.data));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (done2) done2_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, w0, d0;
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        in_data_available = 1'b0; in_data = '0; port_busy = 1'b0;
        address_mat_c = '0; address_stride_c = '0; validity_mask = '0;
        cur_base = '0; cur_stride = '0; cur_mask = '0; k_idx = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_flags", 64'({wr_valid, busy, done, overflow, bram_we}), 64'd0);
        check_eq("rst_addr",  64'(bram_addr),  64'd0);
        check_eq("rst_wdata", 64'(bram_wdata), 64'd0);
        check_eq("rst_flags2", 64'({wr_valid2, busy2, done2, overflow2}), 64'd0);
        reset = 1'b0;
        tick();

        // back-to-back rows, free port: one write per cycle, done right after
        start_job(10'h040, 8'd4, 4'hF, 1);
        check_eq("busy_active", 64'(busy), 64'd1);
        wr_cyc_q.delete();
        c0 = cyc;
        for (int i = 0; i < 4; i++) send_row(RW'($urandom), 1);
        wait_done(1, 1, 30);
        check_consecutive("s1", c0 + 1);
        if (wr_cyc_q.size() == 4)
            check_eq("s1_done_lat", 64'(done_cyc - wr_cyc_q[3]), 64'd1);
        check_eq("s1_ovf", 64'(overflow), 64'd0);
        check_eq("s1_done_pulse", 64'(done), 64'd0);
        check_eq("s1_busy_idle", 64'(busy), 64'd0);

        // port held for 6 cycles while all rows arrive
        start_job(10'h080, 8'd2, 4'hF, 1);
        wr_cyc_q.delete();
        port_busy = 1'b1;
        for (int i = 0; i < 4; i++) send_row(RW'($urandom), 1);
        tick(); tick();
        check_eq("s2_no_wr_busy", 64'(wr_cyc_q.size()), 64'd0);
        c0 = cyc;
        port_busy = 1'b0;
        wait_done(1, 2, 30);
        check_consecutive("s2", c0 + 1);
        check_eq("s2_ovf", 64'(overflow), 64'd0);

        // depth-2 instance: rows 2,3 dropped, extra rows ignored;
        // the idle depth-4 instance must not take any of them
        start_job(10'h010, 8'd3, 4'hF, 2);
        check_eq("busy2_active", 64'(busy2), 64'd1);
        wr_cyc_q.delete();
        w0 = wr2_cnt;
        port_busy = 1'b1;
        for (int i = 0; i < 6; i++) send_row(RW'($urandom), (i < 2) ? 2 : 0);
        check_eq("s3_ovf2", 64'(overflow2), 64'd1);
        check_eq("s3_no_wr2_busy", 64'(wr2_cnt - w0), 64'd0);
        port_busy = 1'b0;
        wait_done(2, 1, 30);
        check_eq("s3_nwr2", 64'(wr2_cnt - w0), 64'd2);
        check_eq("s3_idle_ignored", 64'(wr_cyc_q.size()), 64'd0);
        check_eq("s3_idle_ovf", 64'(overflow), 64'd0);

        // partial mask zeroes the disabled lanes
        start_job(10'h200, 8'd1, 4'h5, 1);
        send_row(32'h44332211, 1);
        for (int i = 0; i < 3; i++) send_row(RW'($urandom), 1);
        wait_done(1, 3, 30);

        // address wraps at the top of the address space
        start_job(10'h3FE, 8'd1, 4'hF, 1);
        for (int i = 0; i < 4; i++) send_row(RW'($urandom), 1);
        wait_done(1, 4, 30);

        // restart while active: buffered rows flushed, no done for that job
        start_job(10'h0A0, 8'd4, 4'hF, 1);
        port_busy = 1'b1;
        for (int i = 0; i < 3; i++) send_row(RW'($urandom), 0);
        start_job(10'h0C0, 8'd4, 4'h9, 1);
        w0 = wr_cnt;
        d0 = done_cnt;
        port_busy = 1'b0;
        tick(); tick(); tick();
        check_eq("s6_flushed", 64'(wr_cnt - w0), 64'd0);
        for (int i = 0; i < 4; i++) send_row(RW'($urandom), 1);
        wait_done(1, d0 + 1, 30);
        check_eq("s6_nwr", 64'(wr_cnt - w0), 64'd4);
        check_eq("s6_one_done", 64'(done_cnt - d0), 64'd1);

        // reset after 2 of 4 writes
        start_job(10'h300, 8'd2, 4'hF, 1);
        port_busy = 1'b1;
        for (int i = 0; i < 4; i++) send_row(RW'($urandom), 1);
        w0 = wr_cnt;
        port_busy = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_eq("s7_two_wr", 64'(wr_cnt - w0), 64'd2);
        check_eq("s7_rst_flags", 64'({wr_valid, busy, done, overflow, bram_we}), 64'd0);
        check_eq("s7_rst_addr",  64'(bram_addr),  64'd0);
        check_eq("s7_rst_wdata", 64'(bram_wdata), 64'd0);
        exp_q.delete();
        tick(); tick();
        reset = 1'b0;
        w0 = wr_cnt;
        d0 = done_cnt;
        repeat (5) tick();
        check_eq("s7_no_wr_after", 64'(wr_cnt - w0), 64'd0);
        check_eq("s7_idle", 64'({busy, done_cnt != d0}), 64'd0);
        start_job(10'h120, 8'd5, 4'hF, 1);
        for (int i = 0; i < 4; i++) send_row(RW'($urandom), 1);
        wait_done(1, d0 + 1, 30);
        check_eq("s7_nwr", 64'(wr_cnt - w0), 64'd4);

        tick();
        check_eq("sb_empty",  64'(exp_q.size()),  64'd0);
        check_eq("sb2_empty", 64'(exp2_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
